// File: rtl/serial_word_assembler_pkg.sv
// Shared types for the serial word assembler: FSM state encoding and line levels.
package serial_word_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} sw_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/serial_word_assembler_if.sv
// Serial input plus word valid/ready output bundle; parity_err exists only with PARITY_CHECK_EN.
interface serial_word_assembler_if #(parameter int data_width = 4);

  logic                  bit_en;
  logic                  ser_in;
  logic [data_width-1:0] data_out;
  logic                  data_valid;
  logic                  data_ready;
  logic                  frame_err;
  logic                  overrun;
`ifdef PARITY_CHECK_EN
  logic                  parity_err;

  modport master (output bit_en, ser_in, data_ready,
                  input  data_out, data_valid, frame_err, overrun, parity_err);
  modport slave  (input  bit_en, ser_in, data_ready,
                  output data_out, data_valid, frame_err, overrun, parity_err);
`else
  modport master (output bit_en, ser_in, data_ready,
                  input  data_out, data_valid, frame_err, overrun);
  modport slave  (input  bit_en, ser_in, data_ready,
                  output data_out, data_valid, frame_err, overrun);
`endif

endinterface

// File: rtl/serial_word_assembler_word_hold_reg.sv
// One-entry valid/ready holding register; load visible 1 clk later.
// A load arriving while full and not being drained is dropped and flagged by a 1-cycle overrun pulse.
module word_hold_reg #(
  parameter int data_width = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_vld,
  input  logic [data_width-1:0] load_dat,
  output logic [data_width-1:0] out_dat,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic                  overrun
);

  logic can_load;

  // Accepting the held word in the same cycle frees the slot for the new one.
  assign can_load = !out_vld || out_rdy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_dat <= '0;
      out_vld <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (load_vld) begin
        if (can_load) begin
          out_dat <= load_dat;
          out_vld <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_vld && out_rdy) begin
        out_vld <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_word_assembler.sv
// Async-framed serial-to-parallel word assembler; word appears 1 clk after the stop sample.
// Optional even-parity check under PARITY_CHECK_EN; output held in word_hold_reg (drops on overrun).
module serial_word_assembler
  import serial_word_pkg::*;
#(
  parameter int data_width = 4,
  parameter int idx_width  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  serial_word_assembler_if.slave  bus
);

  sw_state_t             state, state_nxt;
  logic [idx_width-1:0]  idx;
  logic [data_width-1:0] shreg;
  logic                  sample_data;
  logic                  word_done;
  logic                  frame_bad;
  logic                  load_vld;
  logic                  frame_err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    sample_data = 1'b0;
    word_done   = 1'b0;
    frame_bad   = 1'b0;
    if (bus.bit_en) begin
      case (state)
        IDLE: if (bus.ser_in == START_BIT) state_nxt = DATA;
        DATA: begin
          sample_data = 1'b1;
          if (idx == idx_width'(data_width - 1)) begin
`ifdef PARITY_CHECK_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
        PARITY: state_nxt = STOP;
        STOP: begin
          state_nxt = IDLE;
          if (bus.ser_in == STOP_BIT) word_done = 1'b1;
          else                        frame_bad = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx   <= '0;
      shreg <= '0;
    end else if (sample_data) begin
      shreg[idx] <= bus.ser_in;
      idx        <= idx + 1'b1;
    end else if (state == IDLE) begin
      idx <= '0;
    end
  end

`ifdef PARITY_CHECK_EN
  logic par_bit;
  logic parity_bad;
  logic parity_err_q;

  // Even parity: data bits plus parity bit must XOR to zero.
  assign parity_bad = word_done && (^{shreg, par_bit});
  assign load_vld   = word_done && !parity_bad;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_bit      <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_bad;
      if (bus.bit_en && state == PARITY) par_bit <= bus.ser_in;
    end
  end

  assign bus.parity_err = parity_err_q;
`else
  assign load_vld = word_done;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) frame_err_q <= 1'b0;
    else        frame_err_q <= frame_bad;
  end

  assign bus.frame_err = frame_err_q;

  word_hold_reg #(.data_width(data_width)) u_hold (
    .clk      (clk),
    .reset    (reset),
    .load_vld (load_vld),
    .load_dat (shreg),
    .out_dat  (bus.data_out),
    .out_vld  (bus.data_valid),
    .out_rdy  (bus.data_ready),
    .overrun  (bus.overrun)
  );

endmodule

// File: tb/tb_serial_word_assembler.sv
// Randomized frame stimulus with a scoreboard: expected words/events queued at issue, popped by a monitor.
module tb_serial_word_assembler;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  serial_word_assembler_if #(.data_width(4)) bus ();

  serial_word_assembler #(.data_width(4), .idx_width(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [3:0] word_q[$];
  string      evt_q[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic expect_evt(string kind);
    checks++;
    if (evt_q.size() == 0) begin
      errors++;
      $display("FAIL evt_%s actual=%s required=none", kind, kind);
    end else if (evt_q[0] != kind) begin
      errors++;
      $display("FAIL evt_order actual=%s required=%s", kind, evt_q[0]);
      void'(evt_q.pop_front());
    end else begin
      void'(evt_q.pop_front());
    end
  endtask

  // Monitor: every DUT-presented word or event must match the head of its queue.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.data_valid && bus.data_ready) begin
        if (word_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL word_unexpected actual=%0h required=none", bus.data_out);
        end else begin
          check("word", 32'(bus.data_out), 32'(word_q.pop_front()));
        end
      end
      if (bus.frame_err) expect_evt("FERR");
      if (bus.overrun)   expect_evt("OVR");
`ifdef PARITY_CHECK_EN
      if (bus.parity_err) expect_evt("PERR");
`endif
      if (bus.frame_err || bus.overrun)
        check("ferr_ovr_excl", 32'(bus.frame_err & bus.overrun), 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(logic b, int period);
    for (int i = 1; i < period; i++) begin
      bus.bit_en = 1'b0;
      bus.ser_in = b;
      step();
    end
    bus.bit_en = 1'b1;
    bus.ser_in = b;
    step();
    bus.bit_en = 1'b0;
    bus.ser_in = 1'b1;
  endtask

  // Frame-level reference: stop=0 is a framing error; otherwise the word is
  // delivered unless dropped (overrun) or it fails even parity.
  task automatic send_frame(logic [3:0] w, logic stop, logic par, int period, bit drop);
    if (!stop) evt_q.push_back("FERR");
`ifdef PARITY_CHECK_EN
    else if ((^w) != par) evt_q.push_back("PERR");
`endif
    else if (drop) evt_q.push_back("OVR");
    else word_q.push_back(w);
    send_bit(1'b0, period);
    for (int i = 0; i < 4; i++) send_bit(w[i], period);
`ifdef PARITY_CHECK_EN
    send_bit(par, period);
`endif
    send_bit(stop, period);
  endtask

  initial begin
    logic [3:0] w;
    logic stop, par;
    int period;

    bus.bit_en     = 1'b0;
    bus.ser_in     = 1'b1;
    bus.data_ready = 1'b1;
    repeat (2) step();
    check("rst_valid", 32'(bus.data_valid), 32'd0);
    check("rst_data", 32'(bus.data_out), 32'd0);
    check("rst_ferr", 32'(bus.frame_err), 32'd0);
    check("rst_ovr", 32'(bus.overrun), 32'd0);
    reset = 1'b1;
    step();

    // Word A: visible one clock after the stop sample, valid for exactly one clock.
    send_frame(4'hA, 1'b1, 1'b0, 1, 0);
    check("a_valid", 32'(bus.data_valid), 32'd1);
    check("a_data", 32'(bus.data_out), 32'hA);
    bus.bit_en = 1'b1;
    step();
    bus.bit_en = 1'b0;
    check("a_valid_drop", 32'(bus.data_valid), 32'd0);

    // Overrun: second word dropped while first is held.
    bus.data_ready = 1'b0;
    send_frame(4'h5, 1'b1, 1'b0, 1, 0);
    send_frame(4'hF, 1'b1, 1'b0, 1, 1);
    check("ovr_pulse", 32'(bus.overrun), 32'd1);
    check("ovr_hold_data", 32'(bus.data_out), 32'h5);
    check("ovr_hold_valid", 32'(bus.data_valid), 32'd1);
    step();
    check("ovr_one_cycle", 32'(bus.overrun), 32'd0);
    check("ovr_still_5", 32'(bus.data_out), 32'h5);
    bus.data_ready = 1'b1;
    step();
    check("ovr_drain", 32'(bus.data_valid), 32'd0);

    // Framing error, then a good frame.
    send_frame(4'hC, 1'b0, 1'b0, 1, 0);
    check("ferr_pulse", 32'(bus.frame_err), 32'd1);
    check("ferr_no_valid", 32'(bus.data_valid), 32'd0);
    step();
    check("ferr_one_cycle", 32'(bus.frame_err), 32'd0);
    send_frame(4'h3, 1'b1, 1'b0, 1, 0);
    check("after_ferr_data", 32'(bus.data_out), 32'h3);

    // Async reset mid-frame, after two data bits.
    step();
    send_bit(1'b0, 1);
    send_bit(1'b1, 1);
    send_bit(1'b0, 1);
    #2 reset = 1'b0;
    #1;
    check("arst_data", 32'(bus.data_out), 32'd0);
    check("arst_valid", 32'(bus.data_valid), 32'd0);
    check("arst_ferr", 32'(bus.frame_err), 32'd0);
    step();
    reset = 1'b1;
    step();
    send_frame(4'h9, 1'b1, 1'b0, 1, 0);
    check("post_rst_data", 32'(bus.data_out), 32'h9);

    // Sparse strobe: every third cycle.
    send_frame(4'hB, 1'b1, 1'b1, 3, 0);
    check("slow_data", 32'(bus.data_out), 32'hB);
    check("slow_valid", 32'(bus.data_valid), 32'd1);

`ifdef PARITY_CHECK_EN
    send_frame(4'h7, 1'b1, 1'b1, 1, 0);
    check("par_ok_data", 32'(bus.data_out), 32'h7);
    step();
    send_frame(4'h7, 1'b1, 1'b0, 1, 0);
    check("par_err_pulse", 32'(bus.parity_err), 32'd1);
    check("par_err_no_valid", 32'(bus.data_valid), 32'd0);
`endif

    for (int n = 0; n < 40; n++) begin
      w      = 4'($urandom_range(0, 15));
      stop   = ($urandom_range(0, 9) != 0);
      par    = (^w) ^ ($urandom_range(0, 9) == 0);
      period = $urandom_range(1, 3);
      send_frame(w, stop, par, period, 0);
      repeat ($urandom_range(0, 3)) step();
    end

    repeat (5) step();
    check("word_q_empty", 32'(word_q.size()), 32'd0);
    check("evt_q_empty", 32'(evt_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
